stopwatch_ctrl: RTL

Sequencing controller for the stopwatch display path. It debounces three push-buttons and runs a run/stop/lap/clear state machine. It also keeps a four-digit BCD elapsed-time count (M:SS.t). Its registered digit outputs feed one 7-segment decoder instance per digit. The block sits between the board keys and the decoder bank; the decoders stay purely combinational.

---
 rtl/stopwatch_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: debounces start/lap/clear keys, runs the
// run/stop/lap FSM and keeps a registered M:SS.t BCD count for the digit decoders.
`timescale 1ns/1ps

// state | meaning
// IDLE  | cleared, count and prescaler at zero, waiting for start
// RUN   | counting, display shows the live count
// STOP  | paused, count and partial tenth held, clear allowed
// LAP   | counting underneath, display frozen at the lap value
module stopwatch_ctrl #(
  parameter int TICK_DIV = 5000000,
  parameter int DEBOUNCE = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_n,
  input  logic       lap_n,
  input  logic       clear_n,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       running,
  output logic       held,
  output logic       overflow
);

  localparam int DBW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int PW  = $clog2(TICK_DIV);
  localparam logic [DBW-1:0] DB_LOAD = DBW'(DEBOUNCE - 1);
  localparam logic [PW-1:0]  PRE_TC  = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP, S_LAP} state_e;

  logic [2:0]     key_raw, sync1_q, sync2_q, level_q, press_q;
  logic [DBW-1:0] db_cnt_q [3];

  assign key_raw = {clear_n, lap_n, start_n};

  // Down-counter per key: reloads while the synced level agrees with the
  // accepted level, accepts the new level when it reaches terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      level_q <= '1;
      press_q <= '0;
      for (int k = 0; k < 3; k++) db_cnt_q[k] <= DB_LOAD;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      for (int k = 0; k < 3; k++) begin
        press_q[k] <= 1'b0;
        if (sync2_q[k] == level_q[k]) begin
          db_cnt_q[k] <= DB_LOAD;
        end else if (db_cnt_q[k] == '0) begin
          level_q[k]  <= sync2_q[k];
          db_cnt_q[k] <= DB_LOAD;
          press_q[k]  <= level_q[k];
        end else begin
          db_cnt_q[k] <= db_cnt_q[k] - DBW'(1);
        end
      end
    end
  end

  logic ev_start, ev_lap, ev_clear;
  assign ev_start = press_q[0];
  assign ev_lap   = press_q[1];
  assign ev_clear = press_q[2];

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [15:0]   cnt_q, cnt_d, disp_q, disp_d;
  logic          ovf_q, ovf_d, running_q, running_d, held_q, held_d;
  logic          clr, counting, tick;

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    case (state_q)
      S_IDLE: if (ev_start) state_d = S_RUN;
      S_RUN: begin
        if (ev_start)    state_d = S_STOP;
        else if (ev_lap) state_d = S_LAP;
      end
      S_LAP: begin
        if (ev_start)    state_d = S_STOP;
        else if (ev_lap) state_d = S_RUN;
      end
      S_STOP: begin
        if (ev_clear) begin
          state_d = S_IDLE;
          clr     = 1'b1;
        end else if (ev_start) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign counting = (state_q == S_RUN) || (state_q == S_LAP);
  assign tick     = counting && (pre_q == PRE_TC);

  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      pre_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (counting) pre_d = tick ? '0 : pre_q + PW'(1);
      if (tick) begin
        if (cnt_q[3:0] < 4'd9) cnt_d[3:0] = cnt_q[3:0] + 4'd1;
        else begin
          cnt_d[3:0] = 4'd0;
          if (cnt_q[7:4] < 4'd9) cnt_d[7:4] = cnt_q[7:4] + 4'd1;
          else begin
            cnt_d[7:4] = 4'd0;
            if (cnt_q[11:8] < 4'd5) cnt_d[11:8] = cnt_q[11:8] + 4'd1;
            else begin
              cnt_d[11:8] = 4'd0;
              if (cnt_q[15:12] < 4'd9) cnt_d[15:12] = cnt_q[15:12] + 4'd1;
              else begin
                cnt_d[15:12] = 4'd0;
                ovf_d        = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  // Outside LAP the display register tracks the live count, so on entry to
  // LAP it already holds the value present in the lap-press cycle.
  assign disp_d    = (state_d == S_LAP) ? disp_q : cnt_d;
  assign running_d = (state_d == S_RUN) || (state_d == S_LAP);
  assign held_d    = (state_d == S_LAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pre_q     <= '0;
      cnt_q     <= '0;
      disp_q    <= '0;
      ovf_q     <= 1'b0;
      running_q <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      disp_q    <= disp_d;
      ovf_q     <= ovf_d;
      running_q <= running_d;
      held_q    <= held_d;
    end
  end

  assign digit0   = disp_q[3:0];
  assign digit1   = disp_q[7:4];
  assign digit2   = disp_q[11:8];
  assign digit3   = disp_q[15:12];
  assign running  = running_q;
  assign held     = held_q;
  assign overflow = ovf_q;

endmodule
